ss_write_range: RTL and testbench

SS_WRITE_RANGE -- requirements
Module: ss_write_range

---
 rtl/ss_write_range.sv | 157 +++++++++++++++
 tb/tb_ss_write_range.sv | 351 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ss_write_range.sv
// ss_write_range: writes a stream of samples into a contiguous, possibly
// wrapping, RAM address range [si..ei]. Samples arrive on a valid/ready
// handshake; every accepted sample becomes one RAM write strobe one cycle
// later. The range ends with a FLUSH cycle (final strobe) and a DONE cycle
// (o_done pulse). Optional feature: define SS_WR_SUM_EN to add the o_sum
// port, a running sum of the written samples.
module ss_write_range #(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 6
) (
  input  logic                    i_clk,
  input  logic                    i_rst,
  input  logic                    i_start,
  input  logic                    i_abort,
  input  logic [ADDR_WIDTH-1:0]   i_addr_si,
  input  logic [ADDR_WIDTH-1:0]   i_addr_ei,
  input  logic [DATA_WIDTH-1:0]   i_data,
  input  logic                    i_valid,
  output logic                    o_ready,
  output logic                    o_we_ram,
  output logic [ADDR_WIDTH-1:0]   o_addr_ram,
  output logic [DATA_WIDTH-1:0]   o_data_ram,
  output logic                    o_busy,
  output logic                    o_done,
  output logic [ADDR_WIDTH:0]     o_count
`ifdef SS_WR_SUM_EN
  ,
  output logic [DATA_WIDTH+ADDR_WIDTH-1:0] o_sum
`endif
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    WRITE = 2'd1,
    FLUSH = 2'd2,
    DONE  = 2'd3
  } state_t;

  state_t                  state_reg;
  logic                    ready_reg;
  logic                    busy_reg;
  logic                    done_reg;
  logic                    we_reg;
  logic [ADDR_WIDTH-1:0]   addr_ram_reg;
  logic [DATA_WIDTH-1:0]   data_ram_reg;
  logic [ADDR_WIDTH-1:0]   addr_reg;   // address the next accepted sample goes to
  logic [ADDR_WIDTH-1:0]   ei_reg;     // last address of the range (inclusive)
  logic [ADDR_WIDTH:0]     count_reg;

  logic accept;
  logic last_sample;

  // ready is only ever high in WRITE, so accepts can only happen there
  assign accept = i_valid && ready_reg;

  // Addresses advance by one from si, so the first time the write address
  // reaches ei is exactly sample L. This also covers the full-range case
  // (ei == si-1), where ei is reached only after every address was written.
  assign last_sample = (addr_reg == ei_reg);

`ifdef SS_WR_SUM_EN
  logic [DATA_WIDTH+ADDR_WIDTH-1:0] sum_reg;

  // Running sum of accepted samples; cleared on start, frozen otherwise
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      sum_reg <= '0;
    end else if (state_reg == IDLE && i_start && !i_abort) begin
      sum_reg <= '0;
    end else if (accept) begin
      sum_reg <= sum_reg + (DATA_WIDTH+ADDR_WIDTH)'(i_data);
    end
  end

  assign o_sum = sum_reg;
`endif

  // Control FSM with registered handshake, status and RAM write outputs
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_reg    <= IDLE;
      ready_reg    <= 1'b0;
      busy_reg     <= 1'b0;
      done_reg     <= 1'b0;
      we_reg       <= 1'b0;
      addr_ram_reg <= '0;
      data_ram_reg <= '0;
      addr_reg     <= '0;
      ei_reg       <= '0;
      count_reg    <= '0;
    end else begin
      // Write path: an accepted sample is written one cycle later. This runs
      // regardless of i_abort so a sample taken in the abort cycle still lands.
      we_reg   <= accept;
      done_reg <= 1'b0;
      if (accept) begin
        addr_ram_reg <= addr_reg;
        data_ram_reg <= i_data;
        addr_reg     <= addr_reg + 1'b1;
        count_reg    <= count_reg + 1'b1;
      end

      case (state_reg)
        IDLE: begin
          // abort wins over start when both arrive together
          if (i_start && !i_abort) begin
            addr_reg  <= i_addr_si;
            ei_reg    <= i_addr_ei;
            count_reg <= '0;
            state_reg <= WRITE;
            ready_reg <= 1'b1;
            busy_reg  <= 1'b1;
          end
        end
        WRITE: begin
          if (i_abort) begin
            state_reg <= IDLE;
            ready_reg <= 1'b0;
            busy_reg  <= 1'b0;
          end else if (accept && last_sample) begin
            state_reg <= FLUSH;
            ready_reg <= 1'b0;
          end
        end
        FLUSH: begin
          // final strobe is on the RAM port during this cycle
          if (i_abort) begin
            state_reg <= IDLE;
            busy_reg  <= 1'b0;
          end else begin
            state_reg <= DONE;
            done_reg  <= 1'b1;
          end
        end
        DONE: begin
          // abort is deliberately ignored here: the range already completed
          state_reg <= IDLE;
          busy_reg  <= 1'b0;
        end
        default: begin
          state_reg <= IDLE;
          ready_reg <= 1'b0;
          busy_reg  <= 1'b0;
        end
      endcase
    end
  end

  assign o_ready    = ready_reg;
  assign o_busy     = busy_reg;
  assign o_done     = done_reg;
  assign o_we_ram   = we_reg;
  assign o_addr_ram = addr_ram_reg;
  assign o_data_ram = data_ram_reg;
  assign o_count    = count_reg;

endmodule

// File: tb/tb_ss_write_range.sv
// Testbench for ss_write_range (default 8-bit data, 6-bit address).
// Expected RAM writes are queued as samples are accepted; a monitor records
// the strobes the DUT actually emits and each scenario task compares them.
module tb_ss_write_range;

  localparam int DW = 8;
  localparam int AW = 6;

  logic          i_clk = 1'b0;
  logic          i_rst;
  logic          i_start;
  logic          i_abort;
  logic [AW-1:0] i_addr_si;
  logic [AW-1:0] i_addr_ei;
  logic [DW-1:0] i_data;
  logic          i_valid;
  logic          o_ready;
  logic          o_we_ram;
  logic [AW-1:0] o_addr_ram;
  logic [DW-1:0] o_data_ram;
  logic          o_busy;
  logic          o_done;
  logic [AW:0]   o_count;
`ifdef SS_WR_SUM_EN
  logic [DW+AW-1:0] o_sum;
`endif

  ss_write_range #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) dut (
    .i_clk      (i_clk),
    .i_rst      (i_rst),
    .i_start    (i_start),
    .i_abort    (i_abort),
    .i_addr_si  (i_addr_si),
    .i_addr_ei  (i_addr_ei),
    .i_data     (i_data),
    .i_valid    (i_valid),
    .o_ready    (o_ready),
    .o_we_ram   (o_we_ram),
    .o_addr_ram (o_addr_ram),
    .o_data_ram (o_data_ram),
    .o_busy     (o_busy),
    .o_done     (o_done),
    .o_count    (o_count)
`ifdef SS_WR_SUM_EN
    ,
    .o_sum      (o_sum)
`endif
  );

  always #5 i_clk = ~i_clk;

  typedef struct {
    logic [AW-1:0] addr;
    logic [DW-1:0] data;
  } exp_t;

  typedef struct {
    logic [AW-1:0] addr;
    logic [DW-1:0] data;
    int            cyc;
  } obs_t;

  exp_t          exp_q[$];
  obs_t          obs_q[$];
  int            done_q[$];
  int            cyc = 0;
  logic [AW-1:0] exp_addr;
  int            tests_run = 0;
  int            tests_failed = 0;

  always @(posedge i_clk) cyc <= cyc + 1;

  // record every strobe and done pulse the DUT produces
  always @(negedge i_clk) begin
    if (o_we_ram === 1'b1) obs_q.push_back('{addr: o_addr_ram, data: o_data_ram, cyc: cyc});
    if (o_done === 1'b1) done_q.push_back(cyc);
  end

  task automatic clear_sb();
    exp_q.delete();
    obs_q.delete();
    done_q.delete();
  endtask

  task automatic do_start(input logic [AW-1:0] si, input logic [AW-1:0] ei);
    i_start   = 1'b1;
    i_addr_si = si;
    i_addr_ei = ei;
    exp_addr  = si;
    @(posedge i_clk); #1;
    i_start = 1'b0;
  endtask

  // present one sample and hold it until the DUT accepts it (bounded)
  task automatic send(input logic [DW-1:0] d, output bit ok);
    ok      = 1'b0;
    i_valid = 1'b1;
    i_data  = d;
    for (int k = 0; k < 32; k++) begin
      @(negedge i_clk);
      if (o_ready === 1'b1) begin
        exp_q.push_back('{addr: exp_addr, data: d});
        exp_addr = exp_addr + 1'b1;
        @(posedge i_clk); #1;
        ok = 1'b1;
        break;
      end
      @(posedge i_clk); #1;
    end
  endtask

  task automatic test_reset();
    i_rst = 1'b1;
    repeat (3) @(posedge i_clk);
    @(negedge i_clk);
    tests_run++; if (o_ready !== 1'b0) begin tests_failed++; $display("FAIL reset_ready got %b want 0", o_ready); end
    tests_run++; if (o_we_ram !== 1'b0) begin tests_failed++; $display("FAIL reset_we got %b want 0", o_we_ram); end
    tests_run++; if (o_addr_ram !== '0) begin tests_failed++; $display("FAIL reset_addr got %0d want 0", o_addr_ram); end
    tests_run++; if (o_data_ram !== '0) begin tests_failed++; $display("FAIL reset_data got %0d want 0", o_data_ram); end
    tests_run++; if (o_busy !== 1'b0) begin tests_failed++; $display("FAIL reset_busy got %b want 0", o_busy); end
    tests_run++; if (o_done !== 1'b0) begin tests_failed++; $display("FAIL reset_done got %b want 0", o_done); end
    tests_run++; if (o_count !== '0) begin tests_failed++; $display("FAIL reset_count got %0d want 0", o_count); end
`ifdef SS_WR_SUM_EN
    tests_run++; if (o_sum !== '0) begin tests_failed++; $display("FAIL reset_sum got %0d want 0", o_sum); end
`endif
    @(posedge i_clk); #1;
    i_rst = 1'b0;
    $display("[TB] reset: outputs checked");
  endtask

  task automatic test_basic();
    bit ok;
    bit all_ok = 1'b1;
    int prev_cyc = 0;
    int last_cyc = 0;
    int n = 0;
    clear_sb();
    do_start(6'd2, 6'd5);
    for (int i = 1; i <= 4; i++) begin send(DW'(10 * i), ok); all_ok &= ok; end
    i_valid = 1'b0;
    for (int k = 0; k < 10 && o_busy !== 1'b0; k++) @(negedge i_clk);
    @(negedge i_clk);
    tests_run++; if (!all_ok) begin tests_failed++; $display("FAIL basic_accept got timeout want 4 accepts"); end
    while (exp_q.size() > 0) begin
      exp_t e = exp_q.pop_front();
      tests_run++;
      if (obs_q.size() == 0) begin
        tests_failed++; $display("FAIL basic_strobe got none want addr %0d data %0d", e.addr, e.data);
      end else begin
        obs_t o = obs_q.pop_front();
        if (o.addr !== e.addr || o.data !== e.data || (n > 0 && o.cyc != prev_cyc + 1)) begin
          tests_failed++;
          $display("FAIL basic_strobe got addr %0d data %0d cyc %0d want addr %0d data %0d cyc %0d",
                   o.addr, o.data, o.cyc, e.addr, e.data, prev_cyc + 1);
        end
        prev_cyc = o.cyc; last_cyc = o.cyc; n++;
      end
    end
    tests_run++; if (obs_q.size() != 0) begin tests_failed++; $display("FAIL basic_extra got %0d extra strobes want 0", obs_q.size()); end
    tests_run++;
    if (done_q.size() != 1 || done_q[0] != last_cyc + 1) begin
      tests_failed++; $display("FAIL basic_done got %0d pulses want 1 at cycle %0d", done_q.size(), last_cyc + 1);
    end
    tests_run++; if (o_count !== 7'd4) begin tests_failed++; $display("FAIL basic_count got %0d want 4", o_count); end
`ifdef SS_WR_SUM_EN
    tests_run++; if (o_sum !== 14'd100) begin tests_failed++; $display("FAIL basic_sum got %0d want 100", o_sum); end
`endif
    $display("[TB] basic: si=2 ei=5, %0d strobes, count=%0d", n, o_count);
  endtask

  task automatic test_wrap();
    bit ok;
    bit all_ok = 1'b1;
    int n = 0;
    clear_sb();
    do_start(6'd62, 6'd1);
    for (int i = 0; i < 4; i++) begin send(DW'(8'hA0 + i), ok); all_ok &= ok; end
    i_valid = 1'b0;
    for (int k = 0; k < 10 && o_busy !== 1'b0; k++) @(negedge i_clk);
    tests_run++; if (!all_ok || o_busy !== 1'b0) begin tests_failed++; $display("FAIL wrap_finish got busy %b want 0", o_busy); end
    while (exp_q.size() > 0) begin
      exp_t e = exp_q.pop_front();
      tests_run++;
      if (obs_q.size() == 0) begin
        tests_failed++; $display("FAIL wrap_strobe got none want addr %0d", e.addr);
      end else begin
        obs_t o = obs_q.pop_front();
        n++;
        if (o.addr !== e.addr || o.data !== e.data) begin
          tests_failed++; $display("FAIL wrap_strobe got addr %0d data %0d want addr %0d data %0d", o.addr, o.data, e.addr, e.data);
        end
      end
    end
    tests_run++; if (obs_q.size() != 0 || done_q.size() != 1) begin tests_failed++; $display("FAIL wrap_tail got %0d extra strobes %0d dones want 0 and 1", obs_q.size(), done_q.size()); end
    tests_run++; if (o_count !== 7'd4) begin tests_failed++; $display("FAIL wrap_count got %0d want 4", o_count); end
    $display("[TB] wrap: si=62 ei=1, %0d strobes, count=%0d", n, o_count);
  endtask

  task automatic test_full();
    bit ok;
    bit all_ok = 1'b1;
    int bad = 0;
    int n = 0;
    clear_sb();
    do_start(6'd0, 6'd63);
    for (int i = 0; i < 64; i++) begin send(8'hFF, ok); all_ok &= ok; end
    i_valid = 1'b0;
    for (int k = 0; k < 10 && o_busy !== 1'b0; k++) @(negedge i_clk);
    tests_run++; if (!all_ok || o_busy !== 1'b0) begin tests_failed++; $display("FAIL full_finish got busy %b want 0", o_busy); end
    tests_run++; if (obs_q.size() != 64) begin tests_failed++; $display("FAIL full_strobes got %0d want 64", obs_q.size()); end
    while (exp_q.size() > 0 && obs_q.size() > 0) begin
      exp_t e = exp_q.pop_front();
      obs_t o = obs_q.pop_front();
      n++;
      if (o.addr !== e.addr || o.data !== e.data) bad++;
    end
    tests_run++; if (bad != 0) begin tests_failed++; $display("FAIL full_content got %0d wrong strobes want 0", bad); end
    tests_run++; if (done_q.size() != 1) begin tests_failed++; $display("FAIL full_done got %0d pulses want 1", done_q.size()); end
    tests_run++; if (o_count !== 7'd64) begin tests_failed++; $display("FAIL full_count got %0d want 64", o_count); end
`ifdef SS_WR_SUM_EN
    tests_run++; if (o_sum !== 14'd16320) begin tests_failed++; $display("FAIL full_sum got %0d want 16320", o_sum); end
`endif
    $display("[TB] full: si=0 ei=63, %0d strobes, count=%0d", n, o_count);
  endtask

  task automatic test_stall();
    bit ok;
    clear_sb();
    do_start(6'd7, 6'd7);
    i_valid = 1'b0;
    repeat (5) @(negedge i_clk);
    tests_run++; if (obs_q.size() != 0 || o_count !== 7'd0) begin tests_failed++; $display("FAIL stall_gap got %0d strobes count %0d want 0 and 0", obs_q.size(), o_count); end
    tests_run++; if (o_busy !== 1'b1 || o_ready !== 1'b1) begin tests_failed++; $display("FAIL stall_wait got busy %b ready %b want 1 1", o_busy, o_ready); end
    @(posedge i_clk); #1;
    send(8'h5A, ok);
    i_valid = 1'b0;
    for (int k = 0; k < 10 && o_busy !== 1'b0; k++) @(negedge i_clk);
    tests_run++;
    if (!ok || obs_q.size() != 1 || exp_q.size() != 1) begin
      tests_failed++; $display("FAIL stall_strobes got %0d want 1", obs_q.size());
    end else if (obs_q[0].addr !== 6'd7 || obs_q[0].data !== 8'h5A) begin
      tests_failed++; $display("FAIL stall_strobe got addr %0d data %0h want addr 7 data 5a", obs_q[0].addr, obs_q[0].data);
    end
    tests_run++; if (o_count !== 7'd1 || done_q.size() != 1) begin tests_failed++; $display("FAIL stall_count got %0d dones %0d want 1 1", o_count, done_q.size()); end
    $display("[TB] stall: si=ei=7, %0d strobes, count=%0d", obs_q.size(), o_count);
  endtask

  task automatic test_abort();
    bit ok1;
    bit ok2;
    int n = 0;
    clear_sb();
    do_start(6'd10, 6'd13);
    send(8'h11, ok1);
    // abort and a stray start coincide with the second accept
    i_abort   = 1'b1;
    i_start   = 1'b1;
    i_addr_si = 6'd40;
    send(8'h22, ok2);
    i_abort = 1'b0;
    i_start = 1'b0;
    i_valid = 1'b0;
    @(negedge i_clk);
    tests_run++; if (o_busy !== 1'b0 || o_ready !== 1'b0) begin tests_failed++; $display("FAIL abort_idle got busy %b ready %b want 0 0", o_busy, o_ready); end
    repeat (4) @(negedge i_clk);
    tests_run++; if (o_busy !== 1'b0) begin tests_failed++; $display("FAIL abort_start_ignored got busy %b want 0", o_busy); end
    while (exp_q.size() > 0) begin
      exp_t e = exp_q.pop_front();
      tests_run++;
      if (obs_q.size() == 0) begin
        tests_failed++; $display("FAIL abort_strobe got none want addr %0d", e.addr);
      end else begin
        obs_t o = obs_q.pop_front();
        n++;
        if (o.addr !== e.addr || o.data !== e.data) begin
          tests_failed++; $display("FAIL abort_strobe got addr %0d data %0h want addr %0d data %0h", o.addr, o.data, e.addr, e.data);
        end
      end
    end
    tests_run++; if (!ok1 || !ok2 || obs_q.size() != 0) begin tests_failed++; $display("FAIL abort_strobes got %0d extra want 0", obs_q.size()); end
    tests_run++; if (done_q.size() != 0) begin tests_failed++; $display("FAIL abort_done got %0d pulses want 0", done_q.size()); end
    tests_run++; if (o_count !== 7'd2) begin tests_failed++; $display("FAIL abort_count got %0d want 2", o_count); end
    // abort together with start in IDLE: nothing starts, count untouched
    i_abort = 1'b1;
    i_start = 1'b1;
    @(posedge i_clk); #1;
    i_abort = 1'b0;
    i_start = 1'b0;
    @(negedge i_clk);
    tests_run++; if (o_busy !== 1'b0 || o_count !== 7'd2) begin tests_failed++; $display("FAIL abort_prio got busy %b count %0d want 0 2", o_busy, o_count); end
    $display("[TB] abort: %0d strobes, count=%0d", n, o_count);
  endtask

  task automatic test_reset_mid();
    bit ok;
    bit all_ok = 1'b1;
    int n = 0;
    clear_sb();
    do_start(6'd20, 6'd29);
    for (int i = 0; i < 3; i++) begin send(DW'(8'h30 + i), ok); all_ok &= ok; end
    i_data = 8'h99;
    i_rst  = 1'b1;
    @(posedge i_clk); #1;
    i_rst = 1'b0;
    @(negedge i_clk);
    tests_run++;
    if (o_we_ram !== 1'b0 || o_busy !== 1'b0 || o_ready !== 1'b0 || o_done !== 1'b0 ||
        o_count !== '0 || o_addr_ram !== '0 || o_data_ram !== '0) begin
      tests_failed++;
      $display("FAIL rstmid_outputs got we %b busy %b ready %b done %b count %0d addr %0d data %0d want all 0",
               o_we_ram, o_busy, o_ready, o_done, o_count, o_addr_ram, o_data_ram);
    end
    repeat (5) @(negedge i_clk);
    i_valid = 1'b0;
    while (exp_q.size() > 0) begin
      exp_t e = exp_q.pop_front();
      tests_run++;
      if (obs_q.size() == 0) begin
        tests_failed++; $display("FAIL rstmid_strobe got none want addr %0d", e.addr);
      end else begin
        obs_t o = obs_q.pop_front();
        n++;
        if (o.addr !== e.addr || o.data !== e.data) begin
          tests_failed++; $display("FAIL rstmid_strobe got addr %0d data %0h want addr %0d data %0h", o.addr, o.data, e.addr, e.data);
        end
      end
    end
    tests_run++; if (!all_ok || obs_q.size() != 0 || done_q.size() != 0) begin tests_failed++; $display("FAIL rstmid_tail got %0d strobes %0d dones want 0 0", obs_q.size(), done_q.size()); end
    $display("[TB] reset_mid: %0d strobes before reset", n);
  endtask

  initial begin
    i_rst     = 1'b1;
    i_start   = 1'b0;
    i_abort   = 1'b0;
    i_addr_si = '0;
    i_addr_ei = '0;
    i_data    = '0;
    i_valid   = 1'b0;
    test_reset();
    test_basic();
    test_wrap();
    test_full();
    test_stall();
    test_abort();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
